// File: rtl/cpu_types_pkg.sv
// Shared CPU types. Holds the register-file write-queue entry type and its default depth.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  localparam int unsigned RFQ_DEPTH = 4;

  // valid is cleared when a younger WB write to the same register supersedes the entry
  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    word_t    wdat;
  } rfq_entry_t;

endpackage

// File: rtl/rf_write_queue.sv
// Register-file write-port driver. Merges the single-cycle writeback stage (priority) with the
// multi-cycle mult/div unit; losing mult/div results wait in a small FIFO that decode can search.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   wb_wen/wb_wsel/wb_wdat        writeback write request
//   mc_valid/mc_wsel/mc_wdat      mult/div result, handshaken with mc_ready
//   fwd_rsel1/2 -> fwd_hit1/2, fwd_dat1/2   newest pending queued value per read select
//   stall_req                     queue has starved; WB must be held this cycle
//   rf_wen/rf_wsel/rf_wdat        to the register file write port
//   count                         occupied entries
module rf_write_queue
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH      = RFQ_DEPTH,
  parameter int unsigned STARVE_MAX = 3,
  localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wb_wen,
  input  logic [4:0]    wb_wsel,
  input  logic [31:0]   wb_wdat,
  input  logic          mc_valid,
  input  logic [4:0]    mc_wsel,
  input  logic [31:0]   mc_wdat,
  output logic          mc_ready,
  input  logic [4:0]    fwd_rsel1,
  input  logic [4:0]    fwd_rsel2,
  output logic          fwd_hit1,
  output logic          fwd_hit2,
  output logic [31:0]   fwd_dat1,
  output logic [31:0]   fwd_dat2,
  output logic          stall_req,
  output logic          rf_wen,
  output logic [4:0]    rf_wsel,
  output logic [31:0]   rf_wdat,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  rfq_entry_t    mem_q [DEPTH];
  rfq_entry_t    mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic       full, empty, wb_win, q_use, push;
  rfq_entry_t head;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head      = mem_q[head_q];
  assign mc_ready  = ~RST & ~full;
  assign stall_req = ~empty & (starve_q == SW'(STARVE_MAX));
  assign wb_win    = ~stall_req & wb_wen & (wb_wsel != '0);
  // Queue owns the port whenever it is non-empty and WB does not win (including stall cycles)
  assign q_use     = ~wb_win & ~empty;
  // r0 results are acknowledged but dropped
  assign push      = mc_valid & mc_ready & (mc_wsel != '0);
  assign count     = count_q;

  always_comb begin
    rf_wen  = 1'b0;
    rf_wsel = '0;
    rf_wdat = '0;
    if (!RST) begin
      if (wb_win) begin
        rf_wen  = 1'b1;
        rf_wsel = wb_wsel;
        rf_wdat = wb_wdat;
      end else if (q_use && head.valid) begin
        rf_wen  = 1'b1;
        rf_wsel = head.wsel;
        rf_wdat = head.wdat;
      end
    end
  end

  // Valid bits track occupancy (cleared on pop), so the search need not consult head/count.
  // Walking from the newest slot backward, the first match is the youngest pending write.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit1 = 1'b0;
    fwd_hit2 = 1'b0;
    fwd_dat1 = '0;
    fwd_dat2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = tail_q - PW'(i + 1);
      if (!fwd_hit1 && mem_q[idx].valid && fwd_rsel1 != '0 && mem_q[idx].wsel == fwd_rsel1) begin
        fwd_hit1 = 1'b1;
        fwd_dat1 = mem_q[idx].wdat;
      end
      if (!fwd_hit2 && mem_q[idx].valid && fwd_rsel2 != '0 && mem_q[idx].wsel == fwd_rsel2) begin
        fwd_hit2 = 1'b1;
        fwd_dat2 = mem_q[idx].wdat;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      // WB is program-younger, so a winning WB write makes queued writes to that register dead
      if (wb_win && mem_q[i].wsel == wb_wsel) begin
        mem_d[i].valid = 1'b0;
      end
    end
    if (q_use) begin
      mem_d[head_q].valid = 1'b0;
    end
    // push implies not full, so tail never aliases the popped head here
    if (push) begin
      mem_d[tail_q] = '{valid: 1'b1, wsel: mc_wsel, wdat: mc_wdat};
    end

    head_d  = q_use ? head_q + 1'b1 : head_q;
    tail_d  = push  ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(push) - CW'(q_use);

    if (empty || q_use) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rf_write_queue.sv
// Self-checking bench for rf_write_queue: a cycle-by-cycle vector table followed by
// hand-written sequences for fill/wrap, WAW kill, r0 results and mid-operation reset.
module tb_rf_write_queue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        wb_wen, mc_valid, mc_ready;
  logic [4:0]  wb_wsel, mc_wsel, fwd_rsel1, fwd_rsel2, rf_wsel;
  logic [31:0] wb_wdat, mc_wdat, fwd_dat1, fwd_dat2, rf_wdat;
  logic        fwd_hit1, fwd_hit2, stall_req, rf_wen;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  rf_write_queue dut (
    .CLK       (CLK),
    .RST       (RST),
    .wb_wen    (wb_wen),
    .wb_wsel   (wb_wsel),
    .wb_wdat   (wb_wdat),
    .mc_valid  (mc_valid),
    .mc_wsel   (mc_wsel),
    .mc_wdat   (mc_wdat),
    .mc_ready  (mc_ready),
    .fwd_rsel1 (fwd_rsel1),
    .fwd_rsel2 (fwd_rsel2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_dat1  (fwd_dat1),
    .fwd_dat2  (fwd_dat2),
    .stall_req (stall_req),
    .rf_wen    (rf_wen),
    .rf_wsel   (rf_wsel),
    .rf_wdat   (rf_wdat),
    .count     (count)
  );

  typedef struct {
    logic        wb_wen;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic        mc_valid;
    logic [4:0]  mc_wsel;
    logic [31:0] mc_wdat;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_wen;
    logic [4:0]  e_wsel;
    logic [31:0] e_wdat;
    logic        e_stall;
    logic        e_ready;
    logic [2:0]  e_count;
    logic        e_hit1;
    logic [31:0] e_dat1;
    logic        e_hit2;
    logic [31:0] e_dat2;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] ws, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ms, input logic [31:0] md);
    wb_wen   = we;
    wb_wsel  = ws;
    wb_wdat  = wd;
    mc_valid = mv;
    mc_wsel  = ms;
    mc_wdat  = md;
  endtask

  initial begin
    // wb(en,sel,dat) mc(valid,sel,dat) rsel1 rsel2 | wen wsel wdat stall ready count hit1 dat1 hit2 dat2
    vecs[0]  = '{0, 0, 0,     1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0,     0, 0, 0, 5, 5, 1, 5, 32'hDEADBEEF, 0, 1, 1,
                 1, 32'hDEADBEEF, 1, 32'hDEADBEEF};
    vecs[2]  = '{0, 0, 0,     0, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 1, 'hA1,  1, 8, 'h11, 8, 0, 1, 1, 'hA1, 0, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 2, 'hA2,  1, 8, 'h22, 8, 8, 1, 2, 'hA2, 0, 1, 1, 1, 'h11, 1, 'h11};
    vecs[5]  = '{1, 3, 'hA3,  0, 0, 0, 8, 0, 1, 3, 'hA3, 0, 1, 2, 1, 'h22, 0, 0};
    vecs[6]  = '{1, 4, 'hA4,  0, 0, 0, 8, 0, 1, 4, 'hA4, 0, 1, 2, 1, 'h22, 0, 0};
    vecs[7]  = '{1, 5, 'hA5,  0, 0, 0, 8, 0, 1, 8, 'h11, 1, 1, 2, 1, 'h22, 0, 0};
    vecs[8]  = '{1, 5, 'hA5,  0, 0, 0, 8, 0, 1, 5, 'hA5, 0, 1, 1, 1, 'h22, 0, 0};
    vecs[9]  = '{0, 0, 0,     0, 0, 0, 8, 0, 1, 8, 'h22, 0, 1, 1, 1, 'h22, 0, 0};
    vecs[10] = '{0, 0, 0,     0, 0, 0, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    fwd_rsel1 = '0;
    fwd_rsel2 = '0;
    tick();
    tick();
    chk("rst.mc_ready", mc_ready, 0);
    chk("rst.rf_wen", rf_wen, 0);
    RST = 1'b0;
    #1;
    chk("init.count", count, 0);
    chk("init.mc_ready", mc_ready, 1);
    chk("init.stall", stall_req, 0);

    // Idle path, WB priority, starvation stall and forwarding
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].wb_wen, vecs[i].wb_wsel, vecs[i].wb_wdat,
            vecs[i].mc_valid, vecs[i].mc_wsel, vecs[i].mc_wdat);
      fwd_rsel1 = vecs[i].r1;
      fwd_rsel2 = vecs[i].r2;
      #1;
      chk($sformatf("v%0d.rf_wen", i), rf_wen, vecs[i].e_wen);
      chk($sformatf("v%0d.rf_wsel", i), rf_wsel, vecs[i].e_wsel);
      chk($sformatf("v%0d.rf_wdat", i), rf_wdat, vecs[i].e_wdat);
      chk($sformatf("v%0d.stall", i), stall_req, vecs[i].e_stall);
      chk($sformatf("v%0d.mc_ready", i), mc_ready, vecs[i].e_ready);
      chk($sformatf("v%0d.count", i), count, vecs[i].e_count);
      chk($sformatf("v%0d.hit1", i), fwd_hit1, vecs[i].e_hit1);
      chk($sformatf("v%0d.dat1", i), fwd_dat1, vecs[i].e_dat1);
      chk($sformatf("v%0d.hit2", i), fwd_hit2, vecs[i].e_hit2);
      chk($sformatf("v%0d.dat2", i), fwd_dat2, vecs[i].e_dat2);
      tick();
    end

    // Fill to DEPTH with WB busy; pointers start at 3 so the entries wrap
    fwd_rsel1 = '0;
    fwd_rsel2 = '0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'hB0 + i, 1, 5'(10 + i), 32'h100 + i);
      #1;
      chk($sformatf("fill%0d.ready", i), mc_ready, 1);
      chk($sformatf("fill%0d.count", i), count, 3'(i));
      chk($sformatf("fill%0d.wsel", i), rf_wsel, 1);
      tick();
    end
    drive(1, 1, 32'hB4, 1, 14, 32'h1EE);
    #1;
    chk("full.ready", mc_ready, 0);
    chk("full.count", count, 4);
    chk("full.stall", stall_req, 1);
    chk("full.rf_wen", rf_wen, 1);
    chk("full.rf_wsel", rf_wsel, 10);
    chk("full.rf_wdat", rf_wdat, 32'h100);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("full.no_enq", count, 3);
    for (int j = 1; j < 4; j++) begin
      chk($sformatf("drain%0d.wen", j), rf_wen, 1);
      chk($sformatf("drain%0d.wsel", j), rf_wsel, 5'(10 + j));
      chk($sformatf("drain%0d.wdat", j), rf_wdat, 32'h100 + j);
      tick();
    end
    chk("drain.count", count, 0);
    chk("drain.wen", rf_wen, 0);

    // WAW kill: younger WB write to r9 voids the queued r9
    drive(0, 0, 0, 1, 9, 32'h33);
    tick();
    drive(1, 9, 32'h44, 0, 0, 0);
    fwd_rsel2 = 9;
    #1;
    chk("kill.wb_wsel", rf_wsel, 9);
    chk("kill.wb_wdat", rf_wdat, 32'h44);
    chk("kill.pre_hit2", fwd_hit2, 1);
    chk("kill.pre_dat2", fwd_dat2, 32'h33);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("kill.count", count, 1);
    chk("kill.pop_wen", rf_wen, 0);
    chk("kill.hit2", fwd_hit2, 0);
    tick();
    chk("kill.empty", count, 0);

    // r0 result: acknowledged, never stored or written
    fwd_rsel2 = '0;
    drive(0, 0, 0, 1, 0, 32'h55);
    #1;
    chk("r0.ready", mc_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    fwd_rsel1 = '0;
    #1;
    chk("r0.count", count, 0);
    chk("r0.wen", rf_wen, 0);
    chk("r0.hit1", fwd_hit1, 0);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'hC0 + i, 1, 5'(20 + i), 32'h200 + i);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    fwd_rsel1 = 20;
    #1;
    chk("pre_rst.count", count, 3);
    RST = 1'b1;
    #1;
    chk("mid_rst.ready", mc_ready, 0);
    chk("mid_rst.wen", rf_wen, 0);
    tick();
    RST = 1'b0;
    #1;
    chk("post_rst.count", count, 0);
    chk("post_rst.hit1", fwd_hit1, 0);
    chk("post_rst.wen", rf_wen, 0);
    chk("post_rst.ready", mc_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_queue.md
Name: rf_write_queue

Overview:
- Driver-side counterpart of the register file's write port: owns WEN/wsel/wdat into register_file_if.
- Merges two write sources: the pipeline writeback stage (single-cycle, priority) and the multi-cycle mult/div unit (valid/ready).
- Mult/div results that lose arbitration are held in a small FIFO until the port is free.
- The FIFO is searched so decode can forward pending values before they reach the register file.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- STARVE_MAX, 3, consecutive cycles the non-empty queue may lose arbitration before a stall is requested

Ports:
- CLK  in  1  clock, rising-edge
- RST  in  1  reset; synchronous, active-high
- wb_wen  in  1  writeback stage write request
- wb_wsel  in  5  writeback destination register
- wb_wdat  in  32  writeback data
- mc_valid  in  1  mult/div result valid
- mc_wsel  in  5  mult/div destination register
- mc_wdat  in  32  mult/div data
- mc_ready  out  1  queue can accept a result
- fwd_rsel1, fwd_rsel2  in  5 each  decode read selects to search
- fwd_hit1, fwd_hit2  out  1 each  pending queued write to that register
- fwd_dat1, fwd_dat2  out  32 each  newest queued data for that register
- stall_req  out  1  hazard unit must hold writeback this cycle
- rf_wen  out  1  to register_file_if.WEN
- rf_wsel  out  5  to register_file_if.wsel
- rf_wdat  out  32  to register_file_if.wdat
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (RST high at a CLK edge):
  - Queue empty, head/tail/count = 0, starve counter = 0, all valid bits clear.
  - Reset has priority over every other event and discards entries mid-operation.
  - While RST is high, mc_ready = 0 and rf_wen = 0.
- mc_ready = (count != DEPTH), from registered count only.
  - At full, no enqueue occurs even if a dequeue happens the same cycle.
- Enqueue: mc_valid & mc_ready at an edge.
  - Entry {wsel, wdat} is written at tail and tail advances modulo DEPTH.
  - mc_wsel = 0 is accepted but not stored (no count change).
- Port arbitration (combinational each cycle):
  - stall_req = (count != 0) & (starve == STARVE_MAX).
  - If stall_req: the queue head drives the port and wb_wen is ignored. The pipeline guarantees WB is held.
  - Else if wb_wen & wb_wsel != 0: the WB values drive the port.
  - Else if count != 0: the queue head drives the port and is dequeued at the edge.
  - Else rf_wen = 0, rf_wsel = 0, rf_wdat = 0.
  - The head drives the port only if its valid bit is set. A killed head is popped without asserting rf_wen.
- Starve counter:
  - Increments when count != 0 and WB wins the port; saturates at STARVE_MAX.
  - Clears when the queue uses or pops the port, or when count = 0.
- WAW kill: a WB write to register r that wins the port clears the valid bit of every queued entry with wsel = r. WB is always program-younger; the hazard unit guarantees this.
- Forwarding (combinational):
  - fwd_hitN = 1 if any valid entry has wsel = fwd_rselN and fwd_rselN != 0.
  - fwd_datN comes from the newest such entry (closest to tail); it is 0 when there is no hit.
  - An entry enqueued at edge E is visible from E onward.
  - The entry being dequeued in the current cycle still hits, because the register file writes on negedge.
- Latency: a result accepted at edge E is written to the register file at the earliest in the cycle following E.
- Wrap-around: head/tail use DEPTH-modulo pointers; full vs empty is distinguished by count.
- Simultaneous enqueue + dequeue when not full: count is unchanged.

Decomposition:
- cpu_types_pkg gains:
  - rfq_entry_t: packed struct {logic valid; regbits_t wsel; word_t wdat;}
  - RFQ_DEPTH constant
  - word_t and regbits_t are reused from the package.
- Single module; no sub-module is warranted.
- The newest-match search is one always_comb loop from tail backward.

Test Plan:
- Reset with 3 entries queued -> count = 0, mc_ready = 0 during reset, fwd_hit1 = 0, rf_wen = 0 on the following cycle.
- Idle WB; mc writes r5 = 0xDEADBEEF at E -> rf_wen = 1, rf_wsel = 5, rf_wdat = 0xDEADBEEF in the next cycle; count returns to 0.
- WB busy every cycle; mc enqueues r8 = 0x11, r8 = 0x22 -> fwd_rsel1 = 8 gives hit with 0x22; after 3 lost cycles stall_req = 1 and the head r8 = 0x11 is written.
- Fill 4 entries with WB busy -> mc_ready = 0 at count = 4; a 5th mc_valid is not accepted; drain order matches enqueue order across pointer wrap.
- Queue holds r9 = 0x33; WB writes r9 = 0x44 -> queued r9 is killed; its pop asserts no rf_wen; fwd_rsel2 = 9 gives hit = 0.
- mc_wsel = 0 with mc_valid -> accepted, count unchanged, never written; fwd_rsel1 = 0 gives hit = 0.
